midi_event_parser: RTL and testbench

- Sits directly upstream of the DDS voice/envelope logic, downstream of spi_slave's Avalon-ST source.
- Converts the raw SPI byte stream into complete, validated MIDI note events (note-on/off, note, velocity, channel).
- Buffers events in a small FIFO with a valid/ready handshake, so the DDS consumes events at its own pace.
- Replaces ad-hoc byte counting clocked on a data-valid edge with a proper synchronous state machine.

---
 rtl/midi_event_parser.sv | 210 +++++++++++++++++++++
 tb/tb_midi_event_parser.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_event_parser.sv
// midi_event_parser
//
// Turns the raw received byte stream into validated MIDI note events (note-on / note-off)
// and buffers them in a small FIFO drained through a valid/ready handshake.
//
// Build option: define MIDI_RUNNING_STATUS_EN to let data-byte pairs that follow a completed
// note message reuse its status and channel. Left undefined, a data byte seen while idle is
// a protocol error.
//
// Parameters:
//   CHANNEL    - channel accepted when OMNI = 0 (0..15)
//   OMNI       - 1: accept note messages on every channel
//   FIFO_DEPTH - event FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, nreset         - clock (posedge) and asynchronous active-low reset
//   rx_valid, rx_data   - one-cycle strobe per received byte, and the byte itself
//   evt_valid/evt_ready - FIFO head handshake; pop on evt_valid & evt_ready
//   evt_note_on, evt_note, evt_velocity, evt_channel - head event fields (0 when empty)
//   overflow            - one-cycle pulse when a completed event is dropped (FIFO full)
//   proto_err           - one-cycle pulse on a stray data byte or an aborted message
module midi_event_parser #(
  parameter int unsigned CHANNEL    = 0,
  parameter int unsigned OMNI       = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_note_on,
  output logic [6:0] evt_note,
  output logic [6:0] evt_velocity,
  output logic [3:0] evt_channel,
  output logic       overflow,
  output logic       proto_err
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam logic [3:0]  ChanSel = 4'(CHANNEL);
  localparam logic        OmniEn  = (OMNI != 0);
`ifdef MIDI_RUNNING_STATUS_EN
  localparam logic        RsEn    = 1'b1;
`else
  localparam logic        RsEn    = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StWaitNote, StWaitVel, StSkip} state_e;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic [3:0] chan;
  } event_t;

  // ---------------------------------------------------------------------------------------
  // Byte parser
  // ---------------------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic       rs_valid_q, rs_valid_d;
  logic       cmd_on_q, cmd_on_d;    // 1 for 0x9n, 0 for 0x8n
  logic [3:0] chan_q, chan_d;
  logic [6:0] note_q, note_d;
  event_t     stage_q, stage_d;      // completed event waiting for its FIFO write
  logic       stage_valid_q, stage_valid_d;
  logic       proto_err_q, proto_err_d;

  logic is_rt, is_note_status, chan_match;
  assign is_rt          = (rx_data[7:3] == 5'b11111);
  assign is_note_status = (rx_data[7:5] == 3'b100);
  assign chan_match     = OmniEn || (rx_data[3:0] == ChanSel);

  always_comb begin
    state_d       = state_q;
    rs_valid_d    = rs_valid_q;
    cmd_on_d      = cmd_on_q;
    chan_d        = chan_q;
    note_d        = note_q;
    stage_d       = stage_q;
    stage_valid_d = 1'b0;
    proto_err_d   = 1'b0;

    // Real-time bytes may interleave anywhere and leave everything untouched.
    if (rx_valid && !is_rt) begin
      if (rx_data[7]) begin
        // A status byte cuts short any partially received note message, then is handled
        // exactly as if the parser were idle.
        if ((state_q == StWaitNote) || (state_q == StWaitVel)) begin
          proto_err_d = 1'b1;
        end
        if (rx_data[7:4] == 4'hF) begin
          state_d    = StIdle;
          rs_valid_d = 1'b0;
        end else if (is_note_status && chan_match) begin
          cmd_on_d   = rx_data[4];
          chan_d     = rx_data[3:0];
          rs_valid_d = 1'b1;
          state_d    = StWaitNote;
        end else begin
          rs_valid_d = 1'b0;
          state_d    = StSkip;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (RsEn && rs_valid_q) begin
              note_d  = rx_data[6:0];
              state_d = StWaitVel;
            end else begin
              proto_err_d = 1'b1;
            end
          end
          StWaitNote: begin
            note_d  = rx_data[6:0];
            state_d = StWaitVel;
          end
          StWaitVel: begin
            // Note-on with zero velocity is reported as note-off.
            stage_d.on    = cmd_on_q && (rx_data[6:0] != 7'd0);
            stage_d.note  = note_q;
            stage_d.vel   = rx_data[6:0];
            stage_d.chan  = chan_q;
            stage_valid_d = 1'b1;
            state_d       = StIdle;
          end
          StSkip: begin
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= StIdle;
      rs_valid_q    <= 1'b0;
      cmd_on_q      <= 1'b0;
      chan_q        <= 4'd0;
      note_q        <= 7'd0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rs_valid_q    <= rs_valid_d;
      cmd_on_q      <= cmd_on_d;
      chan_q        <= chan_d;
      note_q        <= note_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------------------
  event_t            mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              overflow_q;
  logic              full, pop, do_push;
  event_t            head;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign pop     = evt_valid && evt_ready;
  // When full, a simultaneous pop frees the slot the push needs.
  assign do_push = stage_valid_q && (!full || pop);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= stage_q;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && pop) begin
        count_q <= count_q - CntW'(1);
      end
      overflow_q <= stage_valid_q && full && !pop;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign evt_valid    = (count_q != '0);
  assign evt_note_on  = evt_valid & head.on;
  assign evt_note     = evt_valid ? head.note : 7'd0;
  assign evt_velocity = evt_valid ? head.vel  : 7'd0;
  assign evt_channel  = evt_valid ? head.chan : 4'd0;
  assign overflow     = overflow_q;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_midi_event_parser.sv
// Bench for midi_event_parser: two instances (omni, and channel-3 only) share one byte
// stream; a message-level model predicts the outputs of both every cycle, and a few
// hand-worked sequences pin the model to known answers.
module tb_midi_event_parser;

  typedef struct packed {
    logic       on;
    logic [6:0] note;
    logic [6:0] vel;
    logic [3:0] ch;
  } ev_t;

`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS = 1'b1;
`else
  localparam bit RS = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       evt_ready = 1'b1;

  logic       v   [2];
  logic       on  [2];
  logic       o   [2];
  logic       p   [2];
  logic [6:0] n   [2];
  logic [6:0] vl  [2];
  logic [3:0] c   [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  midi_event_parser #(.CHANNEL(0), .OMNI(1), .FIFO_DEPTH(DEPTH)) u_omni (
    .clk(clk), .nreset(nreset), .rx_valid(rx_valid), .rx_data(rx_data),
    .evt_valid(v[0]), .evt_ready(evt_ready), .evt_note_on(on[0]), .evt_note(n[0]),
    .evt_velocity(vl[0]), .evt_channel(c[0]), .overflow(o[0]), .proto_err(p[0])
  );

  midi_event_parser #(.CHANNEL(3), .OMNI(0), .FIFO_DEPTH(DEPTH)) u_ch3 (
    .clk(clk), .nreset(nreset), .rx_valid(rx_valid), .rx_data(rx_data),
    .evt_valid(v[1]), .evt_ready(evt_ready), .evt_note_on(on[1]), .evt_note(n[1]),
    .evt_velocity(vl[1]), .evt_channel(c[1]), .overflow(o[1]), .proto_err(p[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", nm, k, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------------------
  // Message-level model: a current status (none / accepted note status / ignored status),
  // the data bytes gathered so far, and the FIFO as a ring of events.
  // ---------------------------------------------------------------------------------------
  ev_t        fm    [2][DEPTH];
  int         fh    [2];
  int         fcnt  [2];
  bit         stg_v [2];
  ev_t        stg   [2];
  bit         have  [2];   // some status is in force
  bit         acc   [2];   // that status is an accepted note status
  bit         fresh [2];   // accepted status just arrived, no message completed under it
  int         dcnt  [2];
  logic [7:0] st    [2];
  logic [6:0] dnote [2];
  bit         eo    [2];
  bit         ep    [2];

  function automatic bit accepts(input int k, input logic [7:0] b);
    if (b[7:5] != 3'b100) return 1'b0;
    return (k == 0) ? 1'b1 : (b[3:0] == 4'd3);
  endfunction

  task automatic m_reset(input int k);
    fh[k] = 0; fcnt[k] = 0; stg_v[k] = 0; have[k] = 0; acc[k] = 0; fresh[k] = 0;
    dcnt[k] = 0; st[k] = 0; dnote[k] = 0; eo[k] = 0; ep[k] = 0;
  endtask

  task automatic m_step(input int k);
    bit   pop, full;
    ev_t  e;
    logic [7:0] b;
    pop  = (fcnt[k] > 0) && evt_ready;
    full = (fcnt[k] == DEPTH);
    if (pop) begin
      fh[k] = (fh[k] + 1) % DEPTH;
      fcnt[k]--;
    end
    eo[k] = 0;
    if (stg_v[k]) begin
      if (!full || pop) begin
        fm[k][(fh[k] + fcnt[k]) % DEPTH] = stg[k];
        fcnt[k]++;
      end else begin
        eo[k] = 1;
      end
    end
    stg_v[k] = 0;
    ep[k] = 0;
    b = rx_data;
    if (rx_valid && b < 8'hF8) begin
      if (b[7]) begin
        if (acc[k] && have[k] && (fresh[k] || dcnt[k] == 1)) ep[k] = 1;
        dcnt[k] = 0;
        fresh[k] = 0;
        if (b >= 8'hF0) begin
          have[k] = 0; acc[k] = 0;
        end else if (accepts(k, b)) begin
          have[k] = 1; acc[k] = 1; fresh[k] = 1; st[k] = b;
        end else begin
          have[k] = 1; acc[k] = 0;
        end
      end else if (!have[k]) begin
        ep[k] = 1;
      end else if (acc[k]) begin
        if (dcnt[k] == 0) begin
          dnote[k] = b[6:0];
          dcnt[k] = 1;
        end else begin
          e.on  = (st[k][7:4] == 4'h9) && (b[6:0] != 7'd0);
          e.note = dnote[k];
          e.vel  = b[6:0];
          e.ch   = st[k][3:0];
          stg[k] = e;
          stg_v[k] = 1;
          dcnt[k] = 0;
          fresh[k] = 0;
          if (!RS) have[k] = 0;
        end
      end
    end
  endtask

  // Single compare process: advance the model on each edge, then check both instances.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!nreset) m_reset(k);
      else m_step(k);
    end
    #1;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("evt_valid", k, 32'(v[k]), 32'(fcnt[k] > 0));
        chk("event", k, 32'({on[k], n[k], vl[k], c[k]}),
            32'((fcnt[k] > 0) ? fm[k][fh[k]] : ev_t'(0)));
        chk("overflow", k, 32'(o[k]), 32'(eo[k]));
        chk("proto_err", k, 32'(p[k]), 32'(ep[k]));
      end
    end
  end

  // Pulse and pop counters used by the hand-worked sequences.
  int pops [2] = '{0, 0};
  int ovfs [2] = '{0, 0};
  int perrs[2] = '{0, 0};
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (v[k] && evt_ready) pops[k]++;
      if (o[k]) ovfs[k]++;
      if (p[k]) perrs[k]++;
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 15) return 8'h80 | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 3));
    if (r < 19) return 8'($urandom_range(8'hA0, 8'hEF));
    if (r < 22) return 8'($urandom_range(8'hF0, 8'hF7));
    if (r < 26) return 8'($urandom_range(8'hF8, 8'hFF));
    if (r < 32) return 8'h00;
    return 8'($urandom_range(1, 127));
  endfunction

  int b0, b1, q0, q1;

  initial begin
    chk_en = 1'b1;
    idle(3);
    for (int k = 0; k < 2; k++) begin
      chk("reset_outputs", k, 32'({v[k], on[k], n[k], vl[k], c[k], o[k], p[k]}), 32'd0);
    end
    @(negedge clk);
    nreset = 1'b1;
    evt_ready = 1'b1;
    idle(2);

    // Basic note-on, one cycle of latency after the velocity strobe.
    send(8'h90); send(8'h3C); send(8'h64);
    chk("t1_not_yet", 0, 32'(v[0]), 32'd0);
    idle(1);
    chk("t1_valid", 0, 32'(v[0]), 32'd1);
    chk("t1_event", 0, 32'({on[0], n[0], vl[0], c[0]}), 32'({1'b1, 7'd60, 7'd100, 4'd0}));
    chk("t1_filtered", 1, 32'(v[1]), 32'd0);
    idle(1);
    chk("t1_empty", 0, 32'(v[0]), 32'd0);

    // Zero-velocity note-on becomes note-off; channel filter drops it silently.
    b1 = perrs[1];
    send(8'h91); send(8'h40); send(8'h00);
    idle(1);
    chk("t2_event", 0, 32'({on[0], n[0], vl[0], c[0]}), 32'({1'b0, 7'd64, 7'd0, 4'd1}));
    chk("t2_filtered", 1, 32'(v[1]), 32'd0);
    idle(2);
    chk("t2_no_err", 1, 32'(perrs[1] - b1), 32'd0);
    send(8'h93); send(8'h40); send(8'h10);
    idle(1);
    chk("t2_ch3_event", 1, 32'({v[1], on[1], n[1], vl[1], c[1]}),
        32'({1'b1, 1'b1, 7'd64, 7'd16, 4'd3}));
    idle(2);

    // Real-time byte in the middle of a message.
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    idle(1);
    chk("t3_event", 0, 32'({on[0], n[0], vl[0], c[0]}), 32'({1'b1, 7'd60, 7'd100, 4'd0}));
    idle(1);
    chk("t3_single", 0, 32'(v[0]), 32'd0);

    // Status byte aborts a partial message.
    send(8'h90); send(8'h3C); send(8'h80);
    chk("t4_abort_err", 0, 32'(p[0]), 32'd1);
    send(8'h3E); send(8'h10);
    idle(1);
    chk("t4_event", 0, 32'({on[0], n[0], vl[0], c[0]}), 32'({1'b0, 7'd62, 7'd16, 4'd0}));
    idle(2);

    // Fill the FIFO with the consumer stalled: four held, two dropped.
    @(negedge clk);
    evt_ready = 1'b0;
    b0 = ovfs[0]; b1 = ovfs[1];
    for (int i = 0; i < 6; i++) begin
      send(8'h93); send(8'(10 + i)); send(8'(20 + i));
    end
    idle(3);
    chk("t5_ovf_count", 0, 32'(ovfs[0] - b0), 32'd2);
    chk("t5_ovf_count", 1, 32'(ovfs[1] - b1), 32'd2);
    chk("t5_head", 0, 32'(n[0]), 32'd10);
    chk("t5_head_hold", 1, 32'({n[1], vl[1]}), 32'({7'd10, 7'd20}));
    @(negedge clk);
    evt_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      idle(1);
      chk("t5_pop_order", 0, 32'(n[0]), 32'(10 + i));
    end
    idle(1);
    chk("t5_drained", 0, 32'(v[0]), 32'd0);

    // Running status (or its absence).
    b0 = perrs[0]; q0 = pops[0]; b1 = perrs[1]; q1 = pops[1];
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h50);
    idle(4);
    chk("t6_events", 0, 32'(pops[0] - q0), RS ? 32'd2 : 32'd1);
    chk("t6_errs", 0, 32'(perrs[0] - b0), RS ? 32'd0 : 32'd2);
    chk("t6_ch3_quiet", 1, 32'((pops[1] - q1) + (perrs[1] - b1)), 32'd0);

    // Randomised traffic with stalls and one mid-stream reset.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc == 2000) nreset = 1'b0;
      if (cyc == 2002) nreset = 1'b1;
      rx_valid  = ($urandom_range(0, 3) != 0);
      rx_data   = rand_byte();
      evt_ready = ((cyc % 400) < 90) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rx_valid  = 1'b0;
    evt_ready = 1'b1;
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
